// File: rtl/plru_multiset.sv
// Tree-PLRU replacement engine with one tree and one valid vector per set.
// A miss fills the lowest invalid way first, otherwise the way the tree points at.
module plru_multiset #(
  parameter int WAYS_NUM = 16,
  parameter int SETS_NUM = 4,
  localparam int WAY_W = $clog2(WAYS_NUM),
  localparam int SET_W = (SETS_NUM > 1) ? $clog2(SETS_NUM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             access_valid,
  input  logic [SET_W-1:0] access_set,
  input  logic             access_hit,
  input  logic [WAY_W-1:0] hit_way,
  input  logic             inv_valid,
  input  logic [SET_W-1:0] inv_set,
  input  logic [WAY_W-1:0] inv_way,
  input  logic             flush,
  output logic             victim_valid,
  output logic [WAY_W-1:0] victim_way,
  output logic             set_full
);

  localparam int NODES = WAYS_NUM - 1;

  logic [NODES-1:0]    r_tree  [SETS_NUM];
  logic [WAYS_NUM-1:0] r_valid [SETS_NUM];
  logic                r_victim_valid;
  logic [WAY_W-1:0]    r_victim_way;

  logic [NODES-1:0]    w_tree_cur;
  logic [NODES-1:0]    w_tree_next;
  logic [WAYS_NUM-1:0] w_valid_cur;
  logic                w_has_free;
  logic [WAY_W-1:0]    w_free_way;
  logic [WAY_W-1:0]    w_plru_way;
  logic [WAY_W-1:0]    w_victim;
  logic [WAY_W-1:0]    w_touch_way;

  // Level l of the tree starts at node 2^l-1; p is the way-index prefix walked so far.
  function automatic logic [NODES-1:0] f_touch(input logic [NODES-1:0] tree,
                                               input logic [WAY_W-1:0] way);
    logic [NODES-1:0] t;
    int p;
    int b;
    t = tree;
    p = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = (int'(way) >> (WAY_W - 1 - l)) & 1;
      t[WAY_W'((1 << l) - 1 + p)] = (b == 0);
      p = 2 * p + b;
    end
    return t;
  endfunction

  assign w_tree_cur  = r_tree[access_set];
  assign w_valid_cur = r_valid[access_set];

  always_comb begin : free_search
    w_has_free = 1'b0;
    w_free_way = '0;
    for (int i = WAYS_NUM - 1; i >= 0; i--) begin
      if (!w_valid_cur[WAY_W'(i)]) begin
        w_has_free = 1'b1;
        w_free_way = WAY_W'(i);
      end
    end
  end

  always_comb begin : plru_walk
    int p;
    p = 0;
    for (int l = 0; l < WAY_W; l++) begin
      p = 2 * p + int'(w_tree_cur[WAY_W'((1 << l) - 1 + p)]);
    end
    w_plru_way = WAY_W'(p);
  end

  assign w_victim    = w_has_free ? w_free_way : w_plru_way;
  assign w_touch_way = access_hit ? hit_way : w_victim;
  assign w_tree_next = f_touch(w_tree_cur, w_touch_way);

  // The invalidate is written last so it wins over a same-cycle fill of the same way.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_tree         <= '{default: '0};
      r_valid        <= '{default: '0};
      r_victim_valid <= 1'b0;
      r_victim_way   <= '0;
    end else begin
      r_victim_valid <= 1'b0;
      if (access_valid) begin
        r_tree[access_set] <= w_tree_next;
        if (!access_hit) begin
          r_valid[access_set][w_victim] <= 1'b1;
          r_victim_valid                <= 1'b1;
          r_victim_way                  <= w_victim;
        end
      end
      if (inv_valid) begin
        r_valid[inv_set][inv_way] <= 1'b0;
      end
    end
  end

  assign victim_valid = r_victim_valid;
  assign victim_way   = r_victim_way;
  assign set_full     = &w_valid_cur;

endmodule
